jesd204_fec_parity_gen: RTL and testbench
=========================================

# jesd204_fec_parity_gen

Streaming parity generator for the JESD204C 64B/66B forward-error-correction code, a (2074,2048) shortened binary cyclic (Fire) code with 26 parity bits. It sits in the transmit link layer. It absorbs the 2048-bit message of one FEC block, DATA_WIDTH bits per enabled cycle, and presents the running 26-bit remainder as the parity word. The framer appends that word to the block.

## Interface
- DATA_WIDTH, 64: message bits absorbed per enabled cycle; any value ≥1 (2048/DATA_WIDTH beats per block when it divides).
- FEC_WIDTH, 26: parity width, equal to the degree of g(x).
- POLYNOMIAL, 26'h0220211: low FEC_WIDTH coefficients of g(x)=x^26+x^21+x^17+x^9+x^4+1; x^26 is implicit.
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-low reset: rst=0 at a rising edge clears state.
- shift_en  in  1  absorb data_in this cycle.
- data_in  in  DATA_WIDTH  message slice; bit 0 is earliest in time (the highest-order message coefficient of this slice).
- fec  out  FEC_WIDTH  current remainder/parity; bit FEC_WIDTH-1 is the x^25 coefficient.

## Operation
- State is a FEC_WIDTH-bit register S, driven directly on fec.
- Serial-equivalent step for one bit b: f = b ^ S[FEC_WIDTH-1]; S' = {S[FEC_WIDTH-2:0],1'b0} ^ (f ? POLYNOMIAL : 0).
- On shift_en=1, apply the step for data_in[0], data_in[1], … data_in[DATA_WIDTH-1], in that order, within one cycle. Implement it as an unrolled combinational loop or a precomputed XOR matrix.
- On shift_en=0, S holds.
- After the full 2048-bit message M(x) is absorbed, fec = M(x)·x^26 mod g(x).
- The block does not count bits and does not clear S automatically. The next block starts only after a reset pulse. The framer owns the beat count.
- Linearity: the fec for message A XOR message B equals fec(A) XOR fec(B), starting from S=0.
- data_in is don't-care when shift_en=0. X on data_in must not propagate into S when shift_en=0.

## Timing
- Reset: rst=0 at a rising edge gives S=0, so fec=0 the next cycle. Reset overrides shift_en.
- Latency is 1 cycle. The beat absorbed at edge k is reflected in fec after edge k. Parity is valid the cycle after the last shift_en beat and holds until the next shift_en or reset.
- Reset mid-block discards the partial remainder; absorption restarts from S=0.
- shift_en may be gapped arbitrarily between beats; the result is unchanged.
- Back-to-back beats are accepted every cycle; there is no backpressure.
- The combinational depth of the DATA_WIDTH-step unroll must meet the link clock. A registered XOR-matrix form is preferred over a ripple chain.

## Structure
- Shared package jesd204_fec_pkg holds FEC_WIDTH=26, the POLYNOMIAL constant, the message length 2048 and the codeword length 2074. The decoder/syndrome checker reuses them.
- There is one natural sub-module, jesd204_fec_lfsr_step. It is a combinational FEC_WIDTH-state × DATA_WIDTH-bit next-state function, shared with the receive syndrome calculator. The top level is the register plus the enable/reset mux.

## Test plan
- Reset then 32 beats of all-zero data_in with shift_en=1 → fec=26'h0000000; rst=0 asserted at any time → fec=0 the next cycle.
- Only the last bit set (beat 31, data_in[63]=1, i.e. coefficient x^0) → fec=26'h0220211. Only beat 31, data_in[62]=1 → fec=26'h0440422. Both bits set → fec=26'h0660633 (XOR).
- Only the first message bit set (beat 0, data_in[0]=1, i.e. coefficient x^2047) → fec equals a bit-serial golden model of x^2073 mod g(x). The value is nonzero and stable after beat 31 while shift_en=0.
- Random 2048-bit messages, with shift_en gapped randomly between beats → fec equals the bit-serial model and matches the ungapped run bit-for-bit.
- Reset asserted after 10 beats, then a fresh 32-beat block → fec equals the result of that block alone.
- DATA_WIDTH=32 (64 beats) and DATA_WIDTH=8 builds with the same messages → identical fec to the DATA_WIDTH=64 build.

Source files
------------

// File: rtl/jesd204_fec_pkg.sv
// Shared constants for the JESD204C 64B/66B (2074,2048) shortened Fire code.
// Used by both the transmit parity generator and the receive syndrome checker.
package jesd204_fec_pkg;

  localparam int FEC_WIDTH = 26;
  localparam int MSG_BITS = 2048;
  localparam int CODEWORD_BITS = 2074;

  // Low coefficients of g(x) = x^26 + x^21 + x^17 + x^9 + x^4 + 1; x^26 is implicit.
  localparam logic [FEC_WIDTH-1:0] POLYNOMIAL = 26'h0220211;

endpackage

// File: rtl/jesd204_fec_lfsr_step.sv
// Combinational multi-bit next-state function of the Fire-code division LFSR.
// data[0] is absorbed first; the unrolled loop collapses to a flat XOR matrix.
module jesd204_fec_lfsr_step #(
  parameter int DATA_WIDTH = 64,
  parameter int STATE_WIDTH = 26,
  parameter logic [STATE_WIDTH-1:0] GEN_POLY = 26'h0220211
) (
  input  logic [STATE_WIDTH-1:0] state,
  input  logic [DATA_WIDTH-1:0]  data,
  output logic [STATE_WIDTH-1:0] next_state
);

  logic [STATE_WIDTH-1:0] acc_s;
  logic                   fb_s;

  // Serial division step repeated once per data bit, earliest bit first.
  always_comb begin
    acc_s = state;
    fb_s  = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      fb_s  = data[i] ^ acc_s[STATE_WIDTH-1];
      acc_s = {acc_s[STATE_WIDTH-2:0], 1'b0} ^ (fb_s ? GEN_POLY : {STATE_WIDTH{1'b0}});
    end
    next_state = acc_s;
  end

endmodule

// File: rtl/jesd204_fec_parity_gen.sv
// Streaming parity generator: remainder register fed by the shared LFSR step.
// The framer owns beat counting; a reset pulse starts each new block.
module jesd204_fec_parity_gen
  import jesd204_fec_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [FEC_WIDTH-1:0]  fec
);

  logic [FEC_WIDTH-1:0] state_r;
  logic [FEC_WIDTH-1:0] next_s;

  jesd204_fec_lfsr_step #(
    .DATA_WIDTH (DATA_WIDTH),
    .STATE_WIDTH(FEC_WIDTH),
    .GEN_POLY   (POLYNOMIAL)
  ) u_step (
    .state     (state_r),
    .data      (data_in),
    .next_state(next_s)
  );

  // Remainder register; holding on idle cycles keeps don't-care data out of the state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= {FEC_WIDTH{1'b0}};
    end else if (shift_en) begin
      state_r <= next_s;
    end else begin
      state_r <= state_r;
    end
  end

  assign fec = state_r;

endmodule

// File: tb/tb_jesd204_fec_parity_gen.sv
// Randomised self-checking bench; reference is long division of M(x)*x^26 by g(x).
module tb_jesd204_fec_parity_gen;

  typedef logic [63:0] msg_t [32];

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        shift_en = 1'b0;
  logic [63:0] data_in = 64'd0;
  logic [25:0] fec;
  logic        shift_en32 = 1'b0;
  logic [31:0] data_in32 = 32'd0;
  logic [25:0] fec32;
  logic        shift_en8 = 1'b0;
  logic [7:0]  data_in8 = 8'd0;
  logic [25:0] fec8;

  int tests_run = 0;
  int tests_failed = 0;
  bit [26:0] gpoly;

  always #5 clk = ~clk;

  jesd204_fec_parity_gen #(.DATA_WIDTH(64)) dut (
    .clk(clk), .rst(rst), .shift_en(shift_en), .data_in(data_in), .fec(fec));
  jesd204_fec_parity_gen #(.DATA_WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .shift_en(shift_en32), .data_in(data_in32), .fec(fec32));
  jesd204_fec_parity_gen #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .shift_en(shift_en8), .data_in(data_in8), .fec(fec8));

  // Reference: P(x)*x^26 mod g(x), P = first nbits message bits (bit 0 is highest order).
  function automatic logic [25:0] ref_parity(input msg_t m, input int nbits);
    bit [2073:0] c;
    c = '0;
    for (int j = 0; j < nbits; j++) c[nbits - 1 - j + 26] = m[j / 64][j % 64];
    for (int d = nbits - 1 + 26; d >= 26; d--)
      if (c[d]) for (int k = 0; k <= 26; k++) c[d - 26 + k] = c[d - 26 + k] ^ gpoly[k];
    return c[25:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; shift_en = 1'b0; shift_en32 = 1'b0; shift_en8 = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic feed_block(input msg_t m, input int nbeats, input bit gapped);
    for (int b = 0; b < nbeats; b++) begin
      if (gapped) begin
        repeat ($urandom_range(0, 3)) begin
          shift_en = 1'b0; data_in = {$urandom, $urandom};
          tick();
        end
      end
      shift_en = 1'b1; data_in = m[b];
      tick();
    end
    shift_en = 1'b0;
  endtask

  function automatic msg_t rand_msg();
    msg_t m;
    for (int b = 0; b < 32; b++) m[b] = {$urandom, $urandom};
    return m;
  endfunction

  task automatic test_reset();
    msg_t m;
    do_reset();
    tests_run++;
    if (fec !== 26'h0) begin
      tests_failed++; $display("FAIL reset_state: fec=%h expected %h", fec, 26'h0);
    end
    m = rand_msg();
    m[0] = m[0] | 64'h1;
    feed_block(m, 5, 1'b0);
    rst = 1'b0; shift_en = 1'b1; data_in = {$urandom, $urandom};
    tick();
    rst = 1'b1; shift_en = 1'b0;
    tests_run++;
    if (fec !== 26'h0) begin
      tests_failed++; $display("FAIL reset_overrides_shift: fec=%h expected %h", fec, 26'h0);
    end
  endtask

  task automatic test_zero();
    msg_t m;
    for (int b = 0; b < 32; b++) m[b] = 64'd0;
    do_reset();
    feed_block(m, 32, 1'b0);
    tests_run++;
    if (fec !== 26'h0) begin
      tests_failed++; $display("FAIL zero_block: fec=%h expected %h", fec, 26'h0);
    end
  endtask

  task automatic test_last_bits();
    msg_t m;
    logic [25:0] exp_tab [3];
    logic [63:0] last_tab [3];
    exp_tab[0] = 26'h0220211; last_tab[0] = 64'h8000_0000_0000_0000;
    exp_tab[1] = 26'h0440422; last_tab[1] = 64'h4000_0000_0000_0000;
    exp_tab[2] = 26'h0660633; last_tab[2] = 64'hC000_0000_0000_0000;
    for (int t = 0; t < 3; t++) begin
      for (int b = 0; b < 32; b++) m[b] = 64'd0;
      m[31] = last_tab[t];
      do_reset();
      feed_block(m, 32, 1'b0);
      tests_run++;
      if (fec !== exp_tab[t]) begin
        tests_failed++; $display("FAIL last_bits[%0d]: fec=%h expected %h", t, fec, exp_tab[t]);
      end
    end
  endtask

  task automatic test_first_bit();
    msg_t m;
    logic [25:0] exp;
    for (int b = 0; b < 32; b++) m[b] = 64'd0;
    m[0] = 64'h1;
    exp = ref_parity(m, 2048);
    do_reset();
    feed_block(m, 32, 1'b0);
    tests_run++;
    if (fec !== exp || exp === 26'h0) begin
      tests_failed++; $display("FAIL first_bit: fec=%h expected %h (nonzero)", fec, exp);
    end
    for (int i = 0; i < 6; i++) begin
      shift_en = 1'b0; data_in = 'x;
      tick();
      tests_run++;
      if (fec !== exp) begin
        tests_failed++; $display("FAIL idle_hold[%0d]: fec=%h expected %h", i, fec, exp);
      end
    end
  endtask

  task automatic test_random_gapped();
    msg_t m;
    logic [25:0] exp;
    logic [25:0] ungapped;
    for (int t = 0; t < 4; t++) begin
      m = rand_msg();
      exp = ref_parity(m, 2048);
      do_reset();
      shift_en = 1'b1; data_in = m[0];
      tick();
      shift_en = 1'b0;
      tests_run++;
      if (fec !== ref_parity(m, 64)) begin
        tests_failed++; $display("FAIL one_beat_latency[%0d]: fec=%h expected %h", t, fec, ref_parity(m, 64));
      end
      do_reset();
      feed_block(m, 32, 1'b0);
      ungapped = fec;
      tests_run++;
      if (fec !== exp) begin
        tests_failed++; $display("FAIL random_back_to_back[%0d]: fec=%h expected %h", t, fec, exp);
      end
      do_reset();
      feed_block(m, 32, 1'b1);
      tests_run++;
      if (fec !== exp || fec !== ungapped) begin
        tests_failed++;
        $display("FAIL random_gapped[%0d]: fec=%h expected %h (ungapped %h)", t, fec, exp, ungapped);
      end
    end
  endtask

  task automatic test_reset_mid();
    msg_t a;
    msg_t b;
    logic [25:0] exp;
    a = rand_msg();
    b = rand_msg();
    exp = ref_parity(b, 2048);
    do_reset();
    feed_block(a, 10, 1'b0);
    do_reset();
    feed_block(b, 32, 1'b1);
    tests_run++;
    if (fec !== exp) begin
      tests_failed++; $display("FAIL reset_mid_block: fec=%h expected %h", fec, exp);
    end
  endtask

  task automatic test_linearity();
    msg_t a;
    msg_t b;
    msg_t c;
    logic [25:0] fa;
    logic [25:0] fb;
    a = rand_msg();
    b = rand_msg();
    for (int i = 0; i < 32; i++) c[i] = a[i] ^ b[i];
    do_reset(); feed_block(a, 32, 1'b0); fa = fec;
    do_reset(); feed_block(b, 32, 1'b0); fb = fec;
    do_reset(); feed_block(c, 32, 1'b0);
    tests_run++;
    if (fec !== (fa ^ fb)) begin
      tests_failed++; $display("FAIL linearity: fec=%h expected %h", fec, fa ^ fb);
    end
  endtask

  task automatic test_widths();
    msg_t m;
    logic [25:0] exp;
    for (int t = 0; t < 2; t++) begin
      m = rand_msg();
      exp = ref_parity(m, 2048);
      do_reset();
      for (int b = 0; b < 64; b++) begin
        shift_en32 = 1'b1; data_in32 = m[b / 2][(b % 2) * 32 +: 32];
        tick();
      end
      shift_en32 = 1'b0;
      for (int b = 0; b < 256; b++) begin
        shift_en8 = 1'b1; data_in8 = m[b / 8][(b % 8) * 8 +: 8];
        tick();
        if ($urandom_range(0, 7) == 0) begin
          shift_en8 = 1'b0; data_in8 = 8'($urandom);
          tick();
        end
      end
      shift_en8 = 1'b0;
      tests_run++;
      if (fec32 !== exp) begin
        tests_failed++; $display("FAIL width32[%0d]: fec=%h expected %h", t, fec32, exp);
      end
      tests_run++;
      if (fec8 !== exp) begin
        tests_failed++; $display("FAIL width8[%0d]: fec=%h expected %h", t, fec8, exp);
      end
    end
  endtask

  initial begin
    gpoly = {1'b1, 26'h0220211};
    test_reset();
    test_zero();
    test_last_bits();
    test_first_bit();
    test_random_gapped();
    test_reset_mid();
    test_linearity();
    test_widths();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
